conga_timer: RTL and testbench

Parametrised multi-channel successor to the single conga beat counter. Each of CHANNELS independent lanes counts enabled clock cycles from 0 up to a shared, runtime-loadable limit, then either pauses (stop mode) or wraps to 0 (wrap mode). Every lane reports its count, a sticky done flag and a one-cycle tick. The block feeds the game's per-player beat and timeout logic.

---
 rtl/conga_pkg.sv | 16 +
 rtl/conga_timer_lane.sv | 54 +++++
 rtl/conga_timer.sv | 54 +++++
 tb/tb_conga_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conga_pkg.sv
// Shared types and constants for the conga lane timer: lane state encoding,
// at-limit mode values and the power-up limit.
package conga_pkg;

  typedef enum logic [1:0] {
    LANE_IDLE  = 2'd0,
    LANE_COUNT = 2'd1,
    LANE_PAUSE = 2'd2
  } lane_state_e;

  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam logic [15:0] DEFAULT_MAXCOUNT = 16'd39648;

endpackage

// File: rtl/conga_timer_lane.sv
// One conga timer lane: counts enabled cycles up to limit_i, then pauses (stop)
// or wraps to zero (wrap). go_i restarts the lane from any state.
module conga_timer_lane
  import conga_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             go_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tick_o,
  output logic [1:0]       state_o
);

  lane_state_e      state_q;
  logic [WIDTH-1:0] count_q;
  logic             tick_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LANE_IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (go_i) begin
        state_q <= LANE_COUNT;
        count_q <= '0;
      end else if (state_q == LANE_COUNT) begin
        // >= rather than == so a limit lowered below the count still stops it.
        if (count_q >= limit_i) begin
          if (mode_i == MODE_STOP) begin
            state_q <= LANE_PAUSE;
            tick_q  <= 1'b1;
          end else if (en_i) begin
            count_q <= '0;
            tick_q  <= 1'b1;
          end
        end else if (en_i) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign state_o = state_q;

endmodule

// File: rtl/conga_timer.sv
// Multi-channel conga timer: a shared runtime-loadable limit register feeding
// CHANNELS independent lanes.
module conga_timer
  import conga_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] MAXCOUNT = WIDTH'(DEFAULT_MAXCOUNT)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       go,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [WIDTH-1:0]          limit_in,
  input  logic                      load_limit,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       tick,
  output logic [WIDTH-1:0]          limit
);

  logic [WIDTH-1:0] limit_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      limit_q <= MAXCOUNT;
    end else if (load_limit) begin
      limit_q <= limit_in;
    end
  end

  assign limit = limit_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [1:0] lane_state;

    conga_timer_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .resetn  (resetn),
      .go_i    (go[i]),
      .en_i    (en[i]),
      .mode_i  (mode[i]),
      .limit_i (limit_q),
      .count_o (count[i*WIDTH +: WIDTH]),
      .tick_o  (tick[i]),
      .state_o (lane_state)
    );

    // done is a decode of the registered lane state, so it stays glitch-free.
    assign done[i] = (lane_state == 2'(LANE_PAUSE));
  end

endmodule

// File: tb/tb_conga_timer.sv
// Scoreboard bench for conga_timer: a cycle-level reference model predicts
// every lane's count/done/tick and the limit; a monitor compares each cycle.
module tb_conga_timer;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int EW = W + C + C + C * W;
  localparam int P_IDLE  = 0;
  localparam int P_COUNT = 1;
  localparam int P_PAUSE = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic [C-1:0]     go, en, mode;
  logic [W-1:0]     limit_in;
  logic             load_limit;
  logic [C*W-1:0]   count;
  logic [C-1:0]     done, tick;
  logic [W-1:0]     limit;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  int   m_phase[C];
  int   m_cnt[C];
  logic m_tick[C];
  int   m_lim;

  conga_timer #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .en         (en),
    .mode       (mode),
    .limit_in   (limit_in),
    .load_limit (load_limit),
    .count      (count),
    .done       (done),
    .tick       (tick),
    .limit      (limit)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      m_phase[i] = P_IDLE;
      m_cnt[i]   = 0;
      m_tick[i]  = 1'b0;
    end
    m_lim = 39648;
  endtask

  task automatic model_step(input logic [C-1:0] g, input logic [C-1:0] e,
                            input logic [C-1:0] md, input logic ld,
                            input logic [W-1:0] li);
    for (int i = 0; i < C; i++) begin
      m_tick[i] = 1'b0;
      if (g[i]) begin
        m_phase[i] = P_COUNT;
        m_cnt[i]   = 0;
      end else if (m_phase[i] == P_COUNT) begin
        if (m_cnt[i] >= m_lim) begin
          if (!md[i]) begin
            m_phase[i] = P_PAUSE;
            m_tick[i]  = 1'b1;
          end else if (e[i]) begin
            m_cnt[i]  = 0;
            m_tick[i] = 1'b1;
          end
        end else if (e[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (ld) m_lim = int'(li);
  endtask

  function automatic logic [EW-1:0] model_outputs();
    logic [C*W-1:0] c;
    logic [C-1:0]   d;
    logic [C-1:0]   t;
    for (int i = 0; i < C; i++) begin
      c[i*W +: W] = W'(m_cnt[i]);
      d[i]        = (m_phase[i] == P_PAUSE);
      t[i]        = m_tick[i];
    end
    return {W'(m_lim), t, d, c};
  endfunction

  // ---------------- checking ----------------
  task automatic check_now(input string name, input logic [EW-1:0] act,
                           input logic [EW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  logic [EW-1:0] mon_exp;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check_now("cycle_outputs", {limit, tick, done, count}, mon_exp);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [C-1:0] g, input logic [C-1:0] e,
                      input logic [C-1:0] md, input logic ld,
                      input logic [W-1:0] li);
    @(negedge clk);
    go = g; en = e; mode = md; load_limit = ld; limit_in = li;
    model_step(g, e, md, ld, li);
    exp_q.push_back(model_outputs());
    @(posedge clk);
  endtask

  task automatic idle_inputs();
    go = '0; en = '0; mode = '0; load_limit = 1'b0; limit_in = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_now("reset_state", {limit, tick, done, count}, model_outputs());
    @(negedge clk) resetn = 1'b1;

    // Asynchronous reset mid-count at count=7.
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd100);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 16'd0);
    repeat (7) step(4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd0);
    #3;
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    #1 check_now("async_reset", {limit, tick, done, count}, model_outputs());
    @(negedge clk) resetn = 1'b1;

    // Stop mode, limit 5, lane 0.
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd5);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 16'd0);
    repeat (18) step(4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd0);
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 16'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 16'd0);

    // Wrap mode, limit 3, lane 1.
    step(4'b0000, 4'b0000, 4'b0010, 1'b1, 16'd3);
    step(4'b0010, 4'b0000, 4'b0010, 1'b0, 16'd0);
    repeat (14) step(4'b0000, 4'b0010, 4'b0010, 1'b0, 16'd0);

    // Independence: lane 2 stop with toggling en, lane 3 wrap, limit 4.
    step(4'b0000, 4'b0000, 4'b1000, 1'b1, 16'd4);
    step(4'b1100, 4'b0000, 4'b1000, 1'b0, 16'd0);
    for (int k = 0; k < 24; k++) begin
      logic [C-1:0] g;
      g = (k == 14) ? 4'b0100 : 4'b0000;
      step(g, {1'b1, (k % 2 == 0), 2'b00}, 4'b1000, 1'b0, 16'd0);
    end

    // Limit lowered mid-count: lane 0 at 20 under limit 100, then limit 10.
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd100);
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 16'd0);
    repeat (20) step(4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 16'd10);
    repeat (4) step(4'b0000, 4'b0000, 4'b0000, 1'b0, 16'd0);

    // limit=0: lane 1 wrap ticks every enabled cycle, lane 0 stop pauses at once.
    step(4'b0011, 4'b0000, 4'b0010, 1'b1, 16'd0);
    for (int k = 0; k < 8; k++)
      step(4'b0000, {2'b00, (k != 4), 1'b1}, 4'b0010, 1'b0, 16'd0);

    // go and load_limit on the same edge.
    step(4'b0001, 4'b0000, 4'b0000, 1'b1, 16'd50);
    repeat (5) step(4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd0);
    step(4'b0001, 4'b0001, 4'b0000, 1'b1, 16'd2);
    repeat (6) step(4'b0000, 4'b0001, 4'b0000, 1'b0, 16'd0);

    // Randomised traffic on all lanes.
    for (int k = 0; k < 400; k++) begin
      logic [C-1:0] g;
      for (int i = 0; i < C; i++) g[i] = ($urandom_range(0, 11) == 0);
      step(g, C'($urandom), C'($urandom), ($urandom_range(0, 19) == 0),
           W'($urandom_range(0, 10)));
    end

    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
